// File: rtl/magnitude_dispatch.sv
// Feeds x*x + y*y radicands through a small FIFO into an iterative square-root core, one job at a time.
// Optional watchdog on the core handshake is enabled with `define MAGDISP_WATCHDOG_EN.
module magnitude_dispatch #(
  parameter int IN_W    = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_x,
  input  logic signed [IN_W-1:0] in_y,
  output logic                   sq_start,
  output logic [31:0]            sq_rad,
  input  logic                   sq_busy,
  input  logic                   sq_done,
  input  logic [31:0]            sq_root,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_mag,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state, next;

  logic signed [31:0] x_w, y_w;
  logic [31:0]        rad;
  logic               push, pop, mag_load, wd_expired, wd_fire;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Squares are non-negative, so the sum of two 2^30 maxima lands exactly on 2^31 unsigned.
  assign x_w = 32'(in_x);
  assign y_w = 32'(in_y);
  assign rad = 32'(x_w * x_w) + 32'(y_w * y_w);

  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;

  // NOTE: storage needs no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      out_mag <= '0;
    end else begin
      state <= next;
      if (mag_load) out_mag <= sq_root[15:0];
    end
  end

  assign sq_start  = (state == S_LAUNCH);
  assign sq_rad    = (state == S_LAUNCH) ? mem[rd_ptr] : '0;
  assign out_valid = (state == S_DRAIN);

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    next     = state;
    pop      = 1'b0;
    mag_load = 1'b0;
    wd_fire  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0 && !sq_busy && !out_valid) next = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (sq_busy) begin
          pop  = 1'b1;
          next = S_WAIT;
        end else if (wd_expired) begin
          pop     = 1'b1;
          wd_fire = 1'b1;
          next    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (sq_done) begin
          mag_load = 1'b1;
          next     = S_DRAIN;
        end else if (wd_expired) begin
          wd_fire = 1'b1;
          next    = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (out_ready) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

`ifdef MAGDISP_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  // Counter restarts on every state change, so LAUNCH and WAIT each get a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (next != state || !(state == S_LAUNCH || state == S_WAIT)) wd_cnt <= '0;
      else                                                          wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) err <= 1'b1;
    end
  end

  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));

  logic unused_root;
  assign unused_root = ^sq_root[31:16];
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;

  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0) ^ wd_fire ^ (^sq_root[31:16]);
`endif

endmodule

// File: doc/magnitude_dispatch.md
# magnitude_dispatch

Upstream feeder for the iterative square-root core (`SqrtCore`). It accepts signed (x, y) component pairs on a valid/ready stream and forms the radicand x² + y². It buffers pending radicands in a small FIFO, sequences the core's `start`/`busy`/`done` handshake one job at a time, and returns each root as a vector magnitude on a valid/ready output stream. It sits between the sample front-end and the magnitude consumers of the pipelined datapath.

## Interface

Parameters:
- `IN_W`, 16, signed component width; legal range 2..16, so the radicand always fits 32 bits unsigned.
- `DEPTH`, 4, radicand FIFO depth; power of two, ≥2.
- `TIMEOUT`, 64, watchdog limit in cycles; used only with the macro below.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  component pair valid.
- `in_ready`  out  1  FIFO can accept; equals not-full.
- `in_x`, `in_y`  in  IN_W  signed two's-complement components.
- `sq_start`  out  1  to core `start`.
- `sq_rad`  out  32  to core `rad`.
- `sq_busy`  in  1  from core `busy`.
- `sq_done`  in  1  from core `done`.
- `sq_root`  in  32  from core `root`.
- `out_valid`  out  1  magnitude valid.
- `out_ready`  in  1  consumer accepts.
- `out_mag`  out  16  magnitude, taken from `sq_root[15:0]`.
- `err`  out  1  sticky watchdog flag.

## Operation

- Accept: a pair is accepted on a clock edge where `in_valid && in_ready`.
  - Radicand = x·x + y·y, computed as unsigned 32-bit.
  - The radicand is written to the FIFO tail at that edge.
- FSM states:
  - IDLE → LAUNCH when the FIFO is non-empty, `!sq_busy` and `!out_valid`.
  - LAUNCH: `sq_start=1` and `sq_rad` = FIFO head, both held stable. When `sq_busy=1` is sampled: pop the head, drop `sq_start`, go to WAIT.
  - WAIT: on `sq_done=1`, capture `sq_root[15:0]` into `out_mag`, set `out_valid`, go to DRAIN.
  - DRAIN: on `out_valid && out_ready`, clear `out_valid`, go to IDLE.
- Only one job is ever in flight in the core.
- FIFO boundary rules:
  - `in_ready=0` whenever the FIFO is full, even if a pop occurs in the same cycle (no pass-through).
  - A push and a pop in the same cycle are both honoured.
  - Pointers wrap modulo DEPTH.
  - An occupancy counter runs 0..DEPTH.
- `out_mag` stays stable while `out_valid && !out_ready`.
- Reset values (immediately on `rst=0`): FIFO empty, `in_ready=1`, `sq_start=0`, `sq_rad=0`, `out_valid=0`, `out_mag=0`, `err=0`, FSM in IDLE.
  - A reset in any state, including mid-WAIT, discards all queued and in-flight work.
  - The core shares the same reset.

## Timing

- An accept edge at cycle N into an empty FIFO, with IDLE state and an idle core, gives `sq_start=1` from cycle N+1.
- LAUNCH lasts until `sq_busy` is sampled high, minimum 1 cycle.
- The `out_valid` rising edge falls on the clock edge where `sq_done` is sampled high.
- Back-to-back launch: the next `sq_start` rises no earlier than 1 cycle after the output handshake.
- Input throughput is 1 pair per cycle until the FIFO is full.

## Configuration

- Macro `MAGDISP_WATCHDOG_EN`.
- Defined:
  - A cycle counter runs in LAUNCH and WAIT.
  - If it reaches TIMEOUT without `sq_busy` (in LAUNCH) or `sq_done` (in WAIT), the FSM returns to IDLE, drops `sq_start`, discards the job (popping it if still at the head) and sets `err=1`.
  - `err` clears only on reset.
- Undefined:
  - No counter; the FSM waits indefinitely.
  - `err` is tied to 0.

## Test plan

- (x=3, y=4), `out_ready=1` → `sq_rad=25`; `out_mag=5`; exactly one `out_valid` cycle.
- (−9, 0), then (11, 0), then (0, 0) → radicands 81, 121, 0 in order; `out_mag` 9, 11, 0.
- Five back-to-back pairs with DEPTH=4 while the core is busy → `in_ready` drops after the FIFO reaches 4 entries; all five results emerge in order; none is lost or duplicated.
- (−32768, −32768) → `sq_rad=2147483648`, `out_mag=46340`.
- `out_ready=0` for 10 cycles after `out_valid` → `out_mag` stable throughout and no new `sq_start`; the result is delivered once `out_ready=1`.
- Reset asserted mid-WAIT with 3 entries queued → all outputs take their reset values asynchronously. With `MAGDISP_WATCHDOG_EN`, holding `sq_done=0` gives `err=1` after 64 cycles and a return to IDLE.
